// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the 64x16 instruction memory. While the CPU is halted
//   (run=0) it accepts a byte stream over valid/ready. It packs byte pairs
//   high byte first into 16-bit words and writes them into the user region.
//   The first word goes to BASE_ADDR, which is also the PC reset address.
//
//   Optional feature (compile-time macro IMEM_LOADER_CHECKSUM_EN):
//     After the last word, one extra byte is accepted in state CK. It is
//     compared with the XOR of all data bytes. On a match the block pulses
//     done. On a mismatch it sets error and skips the done pulse.
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   run          CPU run enable; loading only proceeds while low
//   start        one-cycle pulse that begins a load
//   load_len     number of words to load (0..LAST_ADDR-BASE_ADDR+1)
//   in_valid     byte-stream valid
//   in_data      byte-stream data
//   in_ready     loader accepts a byte this cycle
//   imem_we      instruction memory write strobe, one cycle per word
//   imem_waddr   write address
//   imem_wdata   write data {hi,lo}
//   busy         load in progress (state != IDLE)
//   done         one-cycle pulse on successful completion
//   error        sticky error, cleared by the next accepted start
//   words_loaded words written in the current or last load
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 16,
  parameter int BASE_ADDR = 32,
  parameter int LAST_ADDR = 63
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              run,
  input  logic              start,
  input  logic [6:0]        load_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [6:0]        words_loaded
);

  localparam logic [6:0]        MAX_LEN = 7'(LAST_ADDR - BASE_ADDR + 1);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HI   = 3'd1,
    S_LO   = 3'd2,
    S_WR   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CK   = 3'd5,
`endif
    S_DONE = 3'd4
  } state_t;

  state_t     state, state_nx;
  logic [6:0] len_q;
  logic       xfer;
  logic       ld_start, set_err, hi_lat, lo_lat, wr_commit;
  state_t     after_last;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
`endif

  assign xfer = in_valid && in_ready;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign after_last = S_CK;
`else
  assign after_last = S_DONE;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next state and outputs. While busy, a high run aborts the load. The write
  // strobe is also gated by run, so memory is never written during execution.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    imem_we   = 1'b0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    ld_start  = 1'b0;
    set_err   = 1'b0;
    hi_lat    = 1'b0;
    lo_lat    = 1'b0;
    wr_commit = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (run || load_len > MAX_LEN) begin
            set_err = 1'b1;
          end else begin
            ld_start = 1'b1;
            state_nx = (load_len == 7'd0) ? after_last : S_HI;
          end
        end
      end
      S_HI: begin
        in_ready = 1'b1;
        if (run) begin
          set_err  = 1'b1;
          state_nx = S_IDLE;
        end else if (xfer) begin
          hi_lat   = 1'b1;
          state_nx = S_LO;
        end
      end
      S_LO: begin
        in_ready = 1'b1;
        if (run) begin
          set_err  = 1'b1;
          state_nx = S_IDLE;
        end else if (xfer) begin
          lo_lat   = 1'b1;
          state_nx = S_WR;
        end
      end
      S_WR: begin
        if (run) begin
          set_err  = 1'b1;
          state_nx = S_IDLE;
        end else begin
          imem_we   = 1'b1;
          wr_commit = 1'b1;
          state_nx  = (words_loaded + 7'd1 == len_q) ? after_last : S_HI;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CK: begin
        in_ready = 1'b1;
        if (run) begin
          set_err  = 1'b1;
          state_nx = S_IDLE;
        end else if (xfer) begin
          if (in_data == csum) begin
            state_nx = S_DONE;
          end else begin
            set_err  = 1'b1;
            state_nx = S_IDLE;
          end
        end
      end
`endif
      S_DONE: begin
        state_nx = S_IDLE;
        if (run) set_err = 1'b1;
        else     done    = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      error        <= 1'b0;
      words_loaded <= 7'd0;
      len_q        <= 7'd0;
      imem_waddr   <= BASE_A;
      imem_wdata   <= '0;
    end else begin
      if (ld_start)     error <= 1'b0;
      else if (set_err) error <= 1'b1;
      if (ld_start) begin
        words_loaded <= 7'd0;
        len_q        <= load_len;
        imem_waddr   <= BASE_A;
      end else if (wr_commit) begin
        words_loaded <= words_loaded + 7'd1;
        // Hold at the top of the user region instead of wrapping to 0.
        if (imem_waddr != LAST_A) imem_waddr <= imem_waddr + 1'b1;
      end
      if (hi_lat) imem_wdata[DATA_W-1 -: 8] <= in_data;
      if (lo_lat) imem_wdata[7:0]           <= in_data;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)             csum <= 8'h00;
    else if (ld_start)        csum <= 8'h00;
    else if (hi_lat | lo_lat) csum <= csum ^ in_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       run;
  logic       start;
  logic [6:0] load_len;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       imem_we;
  logic [5:0] imem_waddr;
  logic [15:0] imem_wdata;
  logic       busy;
  logic       done;
  logic       error;
  logic [6:0] words_loaded;

  int checks   = 0;
  int failures = 0;

  logic [5:0]  wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  int          done_cnt = 0;
  logic [7:0]  prog[$];

  imem_loader dut (
    .clock(clock), .reset_n(reset_n), .run(run), .start(start),
    .load_len(load_len), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  // Observe writes and done pulses mid-cycle, away from the rising edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (imem_we) begin
        wr_addr_q.push_back(imem_waddr);
        wr_data_q.push_back(imem_wdata);
      end
      if (done) done_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic do_start(input int len);
    start    = 1'b1;
    load_len = 7'(len);
    tick();
    start    = 1'b0;
    load_len = 7'($urandom_range(0, 127));
  endtask

  // Offer one byte after a random idle gap and hold it until it is taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    repeat ($urandom_range(0, 2)) tick();
    in_valid = 1'b1;
    in_data  = b;
    while (!ok && n < 100) begin
      @(negedge clock);
      if (in_ready) ok = 1;
      tick();
      n++;
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (!ok) check("byte_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
    #1;
  endtask

  // Reference: word i of a load holds bytes 2i and 2i+1 at BASE+i.
  // With the checksum build, the trailer is the XOR of all data bytes.
  task automatic run_load(input int len, input bit good_ck, input string tag);
    logic [7:0] ck;
    ck = 8'h00;
    clear_obs();
    do_start(len);
    for (int i = 0; i < 2 * len; i++) begin
      send_byte(prog[i]);
      ck ^= prog[i];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(good_ck ? ck : ck ^ 8'h5A);
`else
    good_ck = 1'b1;
`endif
    wait_idle();
    check({tag, "_nwr"}, wr_addr_q.size(), len);
    for (int i = 0; i < len && i < wr_addr_q.size(); i++) begin
      check({tag, "_addr"}, wr_addr_q[i], 32 + i);
      check({tag, "_data"}, wr_data_q[i], {prog[2*i], prog[2*i+1]});
    end
    check({tag, "_done"}, done_cnt, good_ck ? 1 : 0);
    check({tag, "_words"}, words_loaded, len);
    check({tag, "_err"}, error, good_ck ? 0 : 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    run      = 1'b0;
    start    = 1'b0;
    load_len = 7'd0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_we", imem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_waddr", imem_waddr, 32);
    check("rst_wdata", imem_wdata, 0);
    check("rst_words", words_loaded, 0);
    reset_n = 1'b1;
    tick();

    // Reset while waiting for the low byte.
    clear_obs();
    do_start(2);
    send_byte(8'h12);
    check("mid_busy_before", busy, 1);
    #2 reset_n = 1'b0;
    #2;
    check("midrst_busy", busy, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_we", imem_we, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("midrst_nwr", wr_addr_q.size(), 0);

    // Directed two-word load.
    prog = '{8'h12, 8'h34, 8'h56, 8'h78};
    run_load(2, 1'b1, "basic");

    // Start while running.
    clear_obs();
    run = 1'b1;
    do_start(1);
    #2;
    check("run_start_err", error, 1);
    check("run_start_busy", busy, 0);
    run = 1'b0;
    repeat (3) tick();
    check("run_start_nwr", wr_addr_q.size(), 0);

    // Length out of range.
    do_start(33);
    #2;
    check("len33_err", error, 1);
    check("len33_busy", busy, 0);
    repeat (3) tick();
    check("len33_nwr", wr_addr_q.size(), 0);
    do_start(1);
    #2;
    check("err_cleared", error, 0);
    check("start_busy", busy, 1);
    // Start while busy is ignored.
    do_start(40);
    check("busy_start_err", error, 0);
    prog = '{8'hC3, 8'h3C};
    send_byte(prog[0]);
    send_byte(prog[1]);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'hFF);
`endif
    wait_idle();
    check("one_word_data", wr_data_q.size() > 0 ? wr_data_q[0] : 16'hxxxx, 16'hC33C);
    check("one_word_words", words_loaded, 1);

    // Full fill with random bytes and random valid gaps.
    prog.delete();
    for (int i = 0; i < 64; i++) prog.push_back(8'($urandom));
    run_load(32, 1'b1, "full");
    check("full_last_waddr", imem_waddr, 63);

    // Zero-length load.
    run_load(0, 1'b1, "zero");

    // A few random short loads.
    for (int k = 0; k < 4; k++) begin
      int len;
      len = $urandom_range(1, 6);
      prog.delete();
      for (int i = 0; i < 2 * len; i++) prog.push_back(8'($urandom));
      run_load(len, 1'b1, "rand");
    end

    // Abort after the first word of a three-word load.
    clear_obs();
    do_start(3);
    send_byte(8'hA1);
    send_byte(8'hB2);
    tick();
    run = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_err", error, 1);
    repeat (4) tick();
    check("abort_nwr", wr_addr_q.size(), 1);
    check("abort_data", wr_data_q.size() > 0 ? wr_data_q[0] : 16'hxxxx, 16'hA1B2);
    check("abort_done", done_cnt, 0);
    run = 1'b0;
    tick();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum: the word stays written, but error and no done.
    clear_obs();
    do_start(1);
    send_byte(8'hAB);
    send_byte(8'hCD);
    send_byte(8'h00);
    wait_idle();
    check("ck_bad_err", error, 1);
    check("ck_bad_done", done_cnt, 0);
    check("ck_bad_nwr", wr_addr_q.size(), 1);
    check("ck_bad_data", wr_data_q.size() > 0 ? wr_data_q[0] : 16'hxxxx, 16'hABCD);
    prog = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(2, 1'b0, "ck_bad_rand");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
